// File: rtl/ram_pkg.sv
// Shared definitions for the synchronously-cleared RAM: FSM state encoding
// and default geometry.
package ram_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 15;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// Plain storage: one write port and one registered read port, no reset on
// either the array or the read register.
module ram_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register only loads on a read, so it holds between reads.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sync_clear.sv
// Single-port RAM that clears every word to CLEAR_VAL after reset or on
// request, then serves one read or write per cycle.
module ram_sync_clear
  import ram_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              ready,
  output ram_state_e        state_dbg
);

  // Handshake: an access is taken on a rising edge where en=1 and ready=1
  // and clear=0; there is no back-pressure beyond ready, and a read answers
  // with out_valid=1 exactly one cycle later.

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ram_state_e        state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_inc;
  logic              out_valid_q;
  logic              has_read_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = in;
    mem_rd_en = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = CLEAR_VAL;
      end
      ST_READY: begin
        if (!clear && en) begin
          mem_we    = load;
          mem_rd_en = !load;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      has_read_q  <= 1'b0;
    end else begin
      out_valid_q <= mem_rd_en;
      if (mem_rd_en) begin
        has_read_q <= 1'b1;
      end
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_inc;
          // Carry into the extra counter bit marks the last word written.
          if (cnt_inc[ADDR_W]) begin
            state_q <= ST_READY;
          end
        end
        ST_READY: begin
          if (clear) begin
            cnt_q   <= '0;
            state_q <= ST_CLEAR;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .rd_en_i (mem_rd_en),
    .raddr_i (address),
    .rdata_o (mem_rdata)
  );

  // The read register has no reset, so out is masked to zero until the
  // first read after reset.
  assign out       = has_read_q ? mem_rdata : '0;
  assign out_valid = out_valid_q;
  assign ready     = (state_q == ST_READY);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_sync_clear.sv
// Directed bench for ram_sync_clear with a 16-word x 16-bit memory.
module tb_ram_sync_clear;
  import ram_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clock;
  logic              reset;
  logic              clear;
  logic              en;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              ready;
  ram_state_e        state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  ram_sync_clear #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .CLEAR_VAL (16'h0000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .en        (en),
    .load      (load),
    .address   (address),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .ready     (ready),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    en = 1'b1; load = 1'b1; address = a; in = d;
    tick();
    en = 1'b0; load = 1'b0;
    check_eq("wr_no_valid", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    en = 1'b1; load = 1'b0; address = a;
    exp_q.push_back(exp);
    tick();
    en = 1'b0;
    check_eq("rd_valid", {31'b0, out_valid}, 32'd1);
    check_eq("rd_data", {16'b0, out}, {16'b0, exp_q.pop_front()});
  endtask

  // Exactly DEPTH cycles with ready low, then ready high; optionally hammers
  // a write into the clearing memory the whole time.
  task automatic check_clear_window(input string tag, input logic poke);
    for (int k = 0; k < DEPTH; k++) begin
      if (poke) begin
        en = 1'b1; load = 1'b1; address = 4'd3; in = 16'hFFFF;
      end
      check_eq({tag, "_busy"}, {31'b0, ready}, 32'd0);
      if (poke) check_eq({tag, "_poke_nv"}, {31'b0, out_valid}, 32'd0);
      tick();
    end
    en = 1'b0; load = 1'b0;
    check_eq({tag, "_ready"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; en = 1'b0; load = 1'b0;
    address = '0; in = '0;
    repeat (3) tick();
    check_eq("rst_ready", {31'b0, ready}, 32'd0);
    check_eq("rst_out", {16'b0, out}, 32'd0);
    check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_state", {31'b0, state_dbg}, {31'b0, ST_CLEAR});
    reset = 1'b0;

    // initial clear, then every word reads back as zero
    check_clear_window("init", 1'b0);
    for (int a = 0; a < DEPTH; a++) do_read(a[ADDR_W-1:0], 16'h0000);
    tick();
    check_eq("valid_one_shot", {31'b0, out_valid}, 32'd0);

    // two writes, then back-to-back reads
    do_write(4'd0, 16'h0003);
    do_write(4'd1, 16'h0013);
    do_read(4'd0, 16'h0003);
    do_read(4'd1, 16'h0013);
    tick();
    check_eq("b2b_end_valid", {31'b0, out_valid}, 32'd0);
    check_eq("out_hold", {16'b0, out}, 32'h0013);

    // read immediately after write to same address
    do_write(4'd5, 16'hBEEF);
    do_read(4'd5, 16'hBEEF);

    // clear wins over a simultaneous write; en during clear is ignored
    do_write(4'd9, 16'h00AA);
    clear = 1'b1; en = 1'b1; load = 1'b1; address = 4'd2; in = 16'h1234;
    tick();
    clear = 1'b0; en = 1'b0; load = 1'b0;
    check_eq("clr_state", {31'b0, state_dbg}, {31'b0, ST_CLEAR});
    check_eq("clr_drop_valid", {31'b0, out_valid}, 32'd0);
    check_eq("clr_out_hold", {16'b0, out}, 32'hBEEF);
    check_clear_window("clr", 1'b1);
    do_read(4'd2, 16'h0000);
    do_read(4'd9, 16'h0000);
    do_read(4'd3, 16'h0000);
    do_read(4'd5, 16'h0000);

    // reset in the middle of a clear
    do_write(4'd4, 16'h7777);
    do_read(4'd4, 16'h7777);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (7) tick();
    check_eq("mid_busy", {31'b0, ready}, 32'd0);
    check_eq("mid_out_hold", {16'b0, out}, 32'h7777);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_out", {16'b0, out}, 32'd0);
    check_eq("arst_ready", {31'b0, ready}, 32'd0);
    check_eq("arst_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    check_clear_window("rerun", 1'b0);
    do_read(4'd4, 16'h0000);
    do_read(4'd0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
